// File: rtl/mulred_sched.sv
// mulred_sched: round-robin sharing of one two-stage (a*b) mod Q multiplier, Q = 2^(LOGQ-1)+1,
// with a one-hot owner tag on the shared result bus.
module mulred_sched #(
    parameter int LOGQ = 17,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LOGQ-1:0] req_a,
    input  logic [NREQ*LOGQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [NREQ-1:0]      rsp_owner,
    output logic [LOGQ-1:0]      rsp_data,
    input  logic                 rsp_ready,
    output logic                 busy
);
    localparam int K  = LOGQ - 1;
    localparam int PW = $clog2(NREQ);
    localparam int W  = 2 * LOGQ;
    localparam logic [LOGQ+1:0] QW = (LOGQ + 2)'((1 << K) + 1);

    logic [PW-1:0]   ptr, gidx, idx;
    logic [NREQ-1:0] grant;
    logic            adv;
    logic [LOGQ-1:0] opa, opb, red;
    logic            s1_valid, s2_valid;
    logic [W-1:0]    s1_prod;
    logic [NREQ-1:0] s1_owner, s2_owner;
    logic [LOGQ-1:0] s2_data;
    logic [LOGQ+1:0] t0, t1;

    assign adv = !(s2_valid && !rsp_ready);

    // Scan lowest priority first so the requester just after ptr wins last.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + 1 + i) % NREQ);
            if (req_valid[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    assign req_ready = (adv && rst_n) ? grant : '0;
    assign opa = req_a[int'(gidx)*LOGQ +: LOGQ];
    assign opb = req_b[int'(gidx)*LOGQ +: LOGQ];

    // 2^K == -1 mod Q, so p = c0 + c1*2^K + c2*2^2K reduces to c0 - c1 + c2; +Q keeps it positive.
    assign t0  = (LOGQ + 2)'(s1_prod[K-1:0]) + (LOGQ + 2)'(s1_prod[W-1:2*K]) + QW
               - (LOGQ + 2)'(s1_prod[2*K-1:K]);
    assign t1  = (t0 >= QW) ? t0 - QW : t0;
    assign red = LOGQ'((t1 >= QW) ? t1 - QW : t1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_owner <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_owner <= '0;
        end else if (adv) begin
            s1_valid <= |req_ready;
            s1_owner <= req_ready;
            s1_prod  <= W'(opa) * W'(opb);
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            s2_data  <= red;
            if (|req_ready) ptr <= gidx;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_owner = s2_owner;
    assign rsp_data  = s2_data;
    assign busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_mulred_sched.sv
// tb_mulred_sched: directed and randomized checks of mulred_sched against an
// accept-order scoreboard and a rotation model of the arbiter.
module tb_mulred_sched;
    localparam int     LOGQ = 17;
    localparam int     NREQ = 2;
    localparam longint Q    = 65537;

    typedef struct {
        logic [1:0]  own;
        logic [16:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [16:0] a[2];
    logic [16:0] b[2];
    logic [33:0] req_a, req_b;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_owner;
    logic [16:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic        busy;

    int          n_chk = 0, n_fail = 0;
    exp_t        q[$];
    int          last = 0, wait_n = 0, accepted = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_data = '0;

    assign req_a = {a[1], a[0]};
    assign req_b = {b[1], b[0]};

    mulred_sched #(.LOGQ(LOGQ), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_owner(rsp_owner),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mulmod(logic [16:0] x, logic [16:0] y);
        return 17'((longint'(x) * longint'(y)) % Q);
    endfunction

    // One clock: check at the falling edge, then return 1 time unit after the rising edge.
    task automatic cycle();
        logic       stall;
        logic [1:0] eg;
        int         j;
        exp_t       e;
        @(negedge clk);
        stall = rsp_valid && !rsp_ready;
        eg = 2'b00;
        if (!stall) begin
            for (int i = 2; i >= 1; i--)
                if (req_valid[(last + i) % 2]) eg = 2'b01 << ((last + i) % 2);
        end
        chk("grant", {62'd0, req_ready}, {62'd0, eg});
        chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
        if (prev_stall) chk("hold_data", {47'd0, rsp_data}, {47'd0, prev_data});
        if (q.size() != 0 && !rsp_valid) wait_n++;
        else wait_n = 0;
        if (wait_n >= 2) chk("rsp_latency", {63'd0, rsp_valid}, 64'd1);
        if (rsp_valid) begin
            if (q.size() == 0) chk("spurious_rsp", {63'd0, rsp_valid}, 64'd0);
            else begin
                chk("rsp_data", {47'd0, rsp_data}, {47'd0, q[0].d});
                chk("rsp_owner", {62'd0, rsp_owner}, {62'd0, q[0].own});
                if (rsp_ready) void'(q.pop_front());
            end
        end
        if ((req_ready & req_valid) != 2'b00) begin
            j = req_ready[1] ? 1 : 0;
            e.own = req_ready;
            e.d = mulmod(a[j], b[j]);
            q.push_back(e);
            last = j;
            accepted++;
        end
        prev_stall = stall;
        prev_data = rsp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            a[i] = 17'($urandom_range(65536));
            b[i] = 17'($urandom_range(65536));
        end
    endtask

    logic [16:0] ca[4] = '{17'd65536, 17'd65536, 17'd256, 17'd12345};
    logic [16:0] cb[4] = '{17'd65536, 17'd2, 17'd256, 17'd6789};
    logic [16:0] cr[4] = '{17'd1, 17'd65535, 17'd65536, 17'd53919};

    initial begin
        int cyc;
        a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_owner", {62'd0, rsp_owner}, 64'd0);
        chk("rst_data", {47'd0, rsp_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // Single op from requester 0: 3*5.
        req_valid = 2'b01; a[0] = 17'd3; b[0] = 17'd5; rsp_ready = 1'b1;
        #1;
        chk("t1_ready", {62'd0, req_ready}, 64'd1);
        cycle();
        req_valid = 2'b00;
        chk("t1_s1_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t1_s1_busy", {63'd0, busy}, 64'd1);
        cycle();
        chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t1_owner", {62'd0, rsp_owner}, 64'd1);
        chk("t1_data", {47'd0, rsp_data}, 64'd15);
        cycle();

        // Corner products back-to-back from requester 1.
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            a[1] = ca[k]; b[1] = cb[k];
            cycle();
            if (k >= 1) begin
                chk("t2_data", {47'd0, rsp_data}, {47'd0, cr[k-1]});
                chk("t2_owner", {62'd0, rsp_owner}, 64'd2);
            end
        end
        req_valid = 2'b00;
        cycle();
        chk("t2_data_last", {47'd0, rsp_data}, {47'd0, cr[3]});
        cycle();

        // Both requesters continuously valid: grants alternate starting at 0.
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            #1;
            chk("t3_alt", {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            cycle();
        end
        req_valid = 2'b00;
        repeat (3) cycle();

        // Backpressure with requester 0 waiting.
        rsp_ready = 1'b0; req_valid = 2'b01;
        rand_ops(); cycle();
        rand_ops(); cycle();
        rand_ops();
        #1;
        chk("t4_stall_ready", {62'd0, req_ready}, 64'd0);
        chk("t4_stall_busy", {63'd0, busy}, 64'd1);
        cycle();
        cycle();
        rsp_ready = 1'b1;
        #1;
        chk("t4_resume_ready", {62'd0, req_ready}, 64'd1);
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();

        // Asynchronous reset with two ops in flight.
        req_valid = 2'b11;
        rand_ops(); cycle();
        rand_ops(); cycle();
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_owner", {62'd0, rsp_owner}, 64'd0);
        chk("t5_data", {47'd0, rsp_data}, 64'd0);
        q.delete(); last = 0; wait_n = 0; prev_stall = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 2'b11; rand_ops();
        #1;
        chk("t5_first_grant", {62'd0, req_ready}, 64'd2);
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();

        // Randomized traffic.
        accepted = 0; cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            req_valid[0] = ($urandom_range(3) != 0);
            req_valid[1] = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(9) < 7);
            rand_ops();
            cycle();
            cyc++;
        end
        if (accepted < 10000) chk("rand_accepted", 64'(accepted), 64'd10000);
        req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
